// File: rtl/sensor_emu_pkg.sv
// Shared encodings for the sensor emulator scheduler:
// FSM states, emulator START codes and configuration limits.
package sensor_emu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT0 = 3'd1,
        ST_RUN0  = 3'd2,
        ST_RUN1  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam logic [1:0] START_NONE = 2'd0;
    localparam logic [1:0] START_F0   = 2'd1;
    localparam logic [1:0] START_F1   = 2'd2;

    localparam int unsigned MIN_COUNT_DEF = 4;
    localparam logic [31:0] MAX_COUNT     = 32'd65535;

endpackage

// File: rtl/sensor_emu_pass_ctr.sv
// Beat/pass counter shared by both FIFO phases; a completed
// final pass zeroes both counters so the next phase starts clean.
module sensor_emu_pass_ctr
    import sensor_emu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] count,
    input  logic [15:0] reps,
    output logic        pass_done,
    output logic        final_pass,
    output logic        enter_final
);

    logic [15:0] beat_q, beat_d;
    logic [15:0] pass_q, pass_d;

    assign pass_done   = en && (beat_q == count - 16'd1);
    assign final_pass  = (pass_q == reps - 16'd1);
    assign enter_final = pass_done && !final_pass &&
                         (pass_q + 16'd1 == reps - 16'd1);

    always_comb begin
        beat_d = beat_q;
        pass_d = pass_q;
        if (clr) begin
            beat_d = 16'd0;
            pass_d = 16'd0;
        end else if (pass_done) begin
            beat_d = 16'd0;
            pass_d = final_pass ? 16'd0 : pass_q + 16'd1;
        end else if (en) begin
            beat_d = beat_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_q <= 16'd0;
            pass_q <= 16'd0;
        end else begin
            beat_q <= beat_d;
            pass_q <= pass_d;
        end
    end

endmodule

// File: rtl/sensor_emu_sched.sv
// Schedules an emulator alternating FIFO 0 and FIFO 1 passes,
// steering it through its START register one pass ahead.
module sensor_emu_sched
    import sensor_emu_pkg::*;
#(
    parameter int unsigned MIN_COUNT   = MIN_COUNT_DEF,
    parameter int unsigned WDOG_CYCLES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] i_F0_REPEAT,
    input  logic [15:0] i_F1_REPEAT,
    input  logic [31:0] i_CYCLES,
    input  logic        i_GO_wstrobe,
    input  logic        i_STOP_wstrobe,
    input  logic        i_ABORT_wstrobe,
    input  logic [31:0] i_F0_COUNT,
    input  logic [31:0] i_F1_COUNT,
    input  logic [1:0]  i_ACTIVE_FIFO,
    input  logic        i_beat,
    output logic [1:0]  o_START,
    output logic        o_START_wstrobe,
    output logic        o_HARD_STOP_wstrobe,
    output logic        o_BUSY,
    output logic [2:0]  o_STATE,
    output logic [31:0] o_CYCLES_DONE,
    output logic [1:0]  o_ERROR,
    output logic        o_DONE
);

    state_e      state_q, state_d;
    logic [1:0]  start_q, start_d;
    logic        start_we_q, start_we_d;
    logic        hstop_q, hstop_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] cyc_done_q, cyc_done_d;
    logic [31:0] cycles_q, cycles_d;
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [15:0] rep0_q, rep0_d, rep1_q, rep1_d;
    logic        stop_q, stop_d;
    logic        last_q, last_d;
    logic [31:0] wdog_q, wdog_d;

    logic        cfg_ok, stop_now, last_cyc, run1_end;
    logic        ctr_clr, ctr_en, fin_done;
    logic        pass_done, final_pass, enter_final;
    logic [1:0]  exp_fifo, run1_code;
    logic [15:0] sel_cnt, sel_rep;

    assign cfg_ok = (i_F0_COUNT >= MIN_COUNT) && (i_F0_COUNT <= MAX_COUNT) &&
                    (i_F1_COUNT >= MIN_COUNT) && (i_F1_COUNT <= MAX_COUNT) &&
                    (i_F0_REPEAT != 16'd0) && (i_F1_REPEAT != 16'd0);

    // The cycle in progress is the last one when its completion hits the limit.
    assign stop_now  = stop_q | i_STOP_wstrobe;
    assign last_cyc  = (cycles_q != 32'd0) &&
                       ({1'b0, cyc_done_q} + 33'd1 >= {1'b0, cycles_q});
    assign run1_end  = stop_now | last_cyc;
    assign run1_code = run1_end ? START_NONE : START_F0;

    assign exp_fifo = (state_q == ST_RUN1) ? START_F1 : START_F0;
    assign sel_cnt  = (state_q == ST_RUN1) ? cnt1_q : cnt0_q;
    assign sel_rep  = (state_q == ST_RUN1) ? rep1_q : rep0_q;
    assign fin_done = pass_done & final_pass;

    sensor_emu_pass_ctr u_pass_ctr (
        .clk         (clk),
        .resetn      (resetn),
        .clr         (ctr_clr),
        .en          (ctr_en),
        .count       (sel_cnt),
        .reps        (sel_rep),
        .pass_done   (pass_done),
        .final_pass  (final_pass),
        .enter_final (enter_final)
    );

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        start_we_d = 1'b0;
        hstop_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        cyc_done_d = cyc_done_q;
        cycles_d   = cycles_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        rep0_d     = rep0_q;
        rep1_d     = rep1_q;
        stop_d     = stop_q;
        last_d     = last_q;
        wdog_d     = wdog_q;
        ctr_clr    = 1'b0;
        ctr_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_GO_wstrobe && !cfg_ok) begin
                    err_d = err_q | 2'b01;
                end else if (i_GO_wstrobe) begin
                    cnt0_d     = i_F0_COUNT[15:0];
                    cnt1_d     = i_F1_COUNT[15:0];
                    rep0_d     = i_F0_REPEAT;
                    rep1_d     = i_F1_REPEAT;
                    cycles_d   = i_CYCLES;
                    cyc_done_d = 32'd0;
                    err_d      = 2'b00;
                    stop_d     = 1'b0;
                    last_d     = 1'b0;
                    wdog_d     = 32'd0;
                    ctr_clr    = 1'b1;
                    start_d    = START_F0;
                    start_we_d = 1'b1;
                    state_d    = ST_WAIT0;
                end
            end
            ST_WAIT0: begin
                if (i_ABORT_wstrobe) begin
                    hstop_d = 1'b1;
                    ctr_clr = 1'b1;
                    state_d = ST_DRAIN;
                end else if (i_ACTIVE_FIFO == START_F0) begin
                    stop_d  = stop_now;
                    ctr_en  = i_beat;
                    state_d = ST_RUN0;
                    if (rep0_q == 16'd1) begin
                        start_d    = START_F1;
                        start_we_d = 1'b1;
                    end
                end else if (wdog_q == WDOG_CYCLES - 1) begin
                    stop_d  = stop_now;
                    err_d   = err_q | 2'b10;
                    hstop_d = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    stop_d = stop_now;
                    wdog_d = wdog_q + 32'd1;
                end
            end
            ST_RUN0, ST_RUN1: begin
                if (i_ABORT_wstrobe) begin
                    hstop_d = 1'b1;
                    ctr_clr = 1'b1;
                    state_d = ST_DRAIN;
                end else if (i_ACTIVE_FIFO != exp_fifo) begin
                    err_d   = err_q | 2'b10;
                    hstop_d = 1'b1;
                    ctr_clr = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    stop_d = stop_now;
                    ctr_en = i_beat;
                    if (fin_done && state_q == ST_RUN0) begin
                        state_d = ST_RUN1;
                        if (rep1_q == 16'd1) begin
                            start_d    = run1_code;
                            start_we_d = 1'b1;
                            last_d     = run1_end;
                        end
                    end else if (fin_done) begin
                        cyc_done_d = cyc_done_q + 32'd1;
                        if (last_q) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_RUN0;
                            if (rep0_q == 16'd1) begin
                                start_d    = START_F1;
                                start_we_d = 1'b1;
                            end
                        end
                    end else if (enter_final && state_q == ST_RUN0) begin
                        start_d    = START_F1;
                        start_we_d = 1'b1;
                    end else if (enter_final) begin
                        start_d    = run1_code;
                        start_we_d = 1'b1;
                        last_d     = run1_end;
                    end
                end
            end
            ST_DRAIN: begin
                if (i_ABORT_wstrobe) begin
                    hstop_d = 1'b1;
                end else if (i_ACTIVE_FIFO == START_NONE) begin
                    stop_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stop_d = stop_now;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            start_q    <= START_NONE;
            start_we_q <= 1'b0;
            hstop_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 2'b00;
            cyc_done_q <= 32'd0;
            cycles_q   <= 32'd0;
            cnt0_q     <= 16'd0;
            cnt1_q     <= 16'd0;
            rep0_q     <= 16'd0;
            rep1_q     <= 16'd0;
            stop_q     <= 1'b0;
            last_q     <= 1'b0;
            wdog_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            start_we_q <= start_we_d;
            hstop_q    <= hstop_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cyc_done_q <= cyc_done_d;
            cycles_q   <= cycles_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            rep0_q     <= rep0_d;
            rep1_q     <= rep1_d;
            stop_q     <= stop_d;
            last_q     <= last_d;
            wdog_q     <= wdog_d;
        end
    end

    assign o_START             = start_q;
    assign o_START_wstrobe     = start_we_q;
    assign o_HARD_STOP_wstrobe = hstop_q;
    assign o_BUSY              = (state_q != ST_IDLE);
    assign o_STATE             = state_q;
    assign o_CYCLES_DONE       = cyc_done_q;
    assign o_ERROR             = err_q;
    assign o_DONE              = done_q;

endmodule

// File: tb/tb_sensor_emu_sched.sv
// Scoreboard bench for sensor_emu_sched driving a behavioural
// emulator that replays FIFO passes and obeys START/hard-stop.
module tb_sensor_emu_sched;

    localparam int K_START = 0;
    localparam int K_HSTOP = 1;
    localparam int K_DONE  = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] f0_rep = 16'd1, f1_rep = 16'd1;
    logic [31:0] cycles = 32'd1;
    logic        go = 1'b0, stop = 1'b0, abort = 1'b0;
    logic [31:0] f0_cnt = 32'd4, f1_cnt = 32'd4;
    logic [1:0]  active = 2'd0;
    logic        beat = 1'b0;
    logic [1:0]  o_start;
    logic        o_start_we, o_hstop, o_busy, o_done;
    logic [2:0]  o_state;
    logic [31:0] o_cyc_done;
    logic [1:0]  o_err;

    always #5 clk = ~clk;

    sensor_emu_sched dut (
        .clk                 (clk),
        .resetn              (resetn),
        .i_F0_REPEAT         (f0_rep),
        .i_F1_REPEAT         (f1_rep),
        .i_CYCLES            (cycles),
        .i_GO_wstrobe        (go),
        .i_STOP_wstrobe      (stop),
        .i_ABORT_wstrobe     (abort),
        .i_F0_COUNT          (f0_cnt),
        .i_F1_COUNT          (f1_cnt),
        .i_ACTIVE_FIFO       (active),
        .i_beat              (beat),
        .o_START             (o_start),
        .o_START_wstrobe     (o_start_we),
        .o_HARD_STOP_wstrobe (o_hstop),
        .o_BUSY              (o_busy),
        .o_STATE             (o_state),
        .o_CYCLES_DONE       (o_cyc_done),
        .o_ERROR             (o_err),
        .o_DONE              (o_done)
    );

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int cyc = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k, input int v);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got kind=%0d val=%0d expected none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                fails++;
                $display("FAIL sb_event: got kind=%0d val=%0d expected kind=%0d val=%0d",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every strobe or done pulse pops the scoreboard
    always @(negedge clk) begin
        if (resetn) begin
            if (o_start_we) check_ev(K_START, int'(o_start));
            if (o_hstop) check_ev(K_HSTOP, 0);
            if (o_done) begin
                check_ev(K_DONE, 0);
                done_cnt++;
            end
        end
    end

    // Behavioural emulator
    int         emu_idx = 0, emu_lat = 0, emu_beats = 0, emu_cyc = 0;
    int         beat_pct = 100, s2_cyc = -1, l0_cyc = -1;
    logic [1:0] emu_act = 2'd0, emu_start = 2'd0;
    bit         emu_pend = 0, emu_dead = 0, emu_glitch = 0;

    always @(posedge clk) begin
        #1;
        if (!resetn) begin
            emu_act = 0; emu_start = 0; emu_idx = 0; emu_pend = 0;
            active = 0; beat = 0;
        end else begin
            if (beat) begin
                emu_beats++;
                emu_idx++;
                if (emu_idx == int'(emu_act == 2'd1 ? f0_cnt : f1_cnt)) begin
                    emu_idx = 0;
                    if (emu_act == 2'd1 && l0_cyc < 0) l0_cyc = cyc;
                    if (emu_act == 2'd2 && emu_start != 2'd2) emu_cyc++;
                    emu_act = emu_start;
                end
            end
            if (emu_glitch && emu_act == 2'd1 && emu_idx == 1) begin
                emu_act = 2'd2;
                emu_glitch = 0;
            end
            if (o_start_we) begin
                emu_start = o_start;
                if (o_start == 2'd2 && s2_cyc < 0) s2_cyc = cyc;
                if (emu_act == 0 && o_start != 0 && !emu_dead) begin
                    emu_pend = 1;
                    emu_lat = $urandom_range(0, 3);
                end
            end
            if (o_hstop) begin
                emu_act = 0; emu_pend = 0; emu_start = 0; emu_idx = 0;
            end
            if (emu_pend) begin
                if (emu_lat == 0) begin
                    emu_pend = 0;
                    emu_act = emu_start;
                    emu_idx = 0;
                end else begin
                    emu_lat--;
                end
            end
            active = emu_act;
            beat = (emu_act != 0) && ($urandom_range(1, 100) <= beat_pct);
        end
    end

    task automatic emu_clear();
        emu_beats = 0; emu_cyc = 0; s2_cyc = -1; l0_cyc = -1;
        emu_dead = 0; emu_glitch = 0;
    endtask

    task automatic set_cfg(input int c0, input int c1, input int r0,
                           input int r1, input int cy);
        f0_cnt = c0; f1_cnt = c1;
        f0_rep = 16'(r0); f1_rep = 16'(r1);
        cycles = cy;
    endtask

    // START sequence for n full schedule cycles, then done
    task automatic exp_sched(input int n);
        push(K_START, 1);
        for (int c = 1; c <= n; c++) begin
            push(K_START, 2);
            push(K_START, (c == n) ? 0 : 1);
        end
        push(K_DONE, 0);
    endtask

    task automatic pulse_go();
        @(negedge clk); go = 1;
        @(negedge clk); go = 0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1;
        @(negedge clk); stop = 0;
    endtask

    task automatic wait_emu(input string nm, input int act, input int idx, input int cy);
        int i = 0;
        while (!(emu_act == 2'(act) && (idx < 0 || emu_idx == idx) && emu_cyc == cy)
               && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk({nm, "_reached"}, i < 3000, 1);
    endtask

    task automatic wait_done(input string nm);
        int s = done_cnt;
        int i = 0;
        while (done_cnt == s && i < 4000) begin
            @(posedge clk);
            i++;
        end
        repeat (3) @(posedge clk);
        chk({nm, "_done_pulses"}, done_cnt - s, 1);
    endtask

    task automatic post(input string nm, input int cd, input int er, input int bt);
        @(negedge clk);
        chk({nm, "_state"}, o_state, 0);
        chk({nm, "_busy"}, o_busy, 0);
        chk({nm, "_cycles_done"}, o_cyc_done, cd);
        chk({nm, "_error"}, o_err, er);
        chk({nm, "_sb_empty"}, exp_q.size(), 0);
        if (bt >= 0) chk({nm, "_beats"}, emu_beats, bt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c1, r0, r1, cy, n, k;
        repeat (3) @(negedge clk);
        chk("rst_state", o_state, 0);
        chk("rst_start", o_start, 0);
        chk("rst_strobes", {o_start_we, o_hstop, o_done}, 0);
        chk("rst_cycles", o_cyc_done, 0);
        chk("rst_error", o_err, 0);
        resetn = 1;
        repeat (2) @(negedge clk);
        chk("rst_busy", o_busy, 0);

        // Rejected configurations
        set_cfg(3, 6, 2, 1, 2);
        pulse_go();
        repeat (3) @(negedge clk);
        chk("rej_cnt3_err", o_err, 1);
        chk("rej_cnt3_state", o_state, 0);
        set_cfg(4, 65536, 1, 1, 1);
        pulse_go();
        set_cfg(4, 4, 1, 0, 1);
        pulse_go();
        repeat (3) @(negedge clk);
        chk("rej_other_err", o_err, 1);
        chk("rej_other_busy", o_busy, 0);

        // Basic two-cycle schedule
        emu_clear(); beat_pct = 70;
        set_cfg(4, 6, 2, 1, 2);
        exp_sched(2);
        pulse_go();
        wait_done("basic");
        post("basic", 2, 0, 2 * (4 * 2 + 6 * 1));

        // START=2 lead time with back-to-back beats
        emu_clear(); beat_pct = 100;
        set_cfg(4, 5, 1, 1, 1);
        exp_sched(1);
        pulse_go();
        wait_done("lead");
        chk("lead_start2_margin", (l0_cyc - s2_cyc) >= 2 && s2_cyc >= 0, 1);
        post("lead", 1, 0, 4 + 5);

        // Graceful stop in cycle 3 with unlimited cycles
        emu_clear(); beat_pct = 80;
        set_cfg(5, 4, 1, 2, 0);
        exp_sched(3);
        pulse_go();
        wait_emu("stop3", 1, -1, 2);
        pulse_stop();
        wait_done("stop3");
        post("stop3", 3, 0, 3 * (5 + 4 * 2));

        // Abort during the first FIFO 1 pass
        emu_clear(); beat_pct = 100;
        set_cfg(4, 6, 2, 2, 0);
        push(K_START, 1); push(K_START, 2); push(K_HSTOP, 0); push(K_DONE, 0);
        pulse_go();
        wait_emu("abort", 2, 2, 0);
        @(negedge clk); abort = 1;
        @(negedge clk); abort = 0;
        chk("abort_hstop_next", o_hstop, 1);
        wait_done("abort");
        post("abort", 0, 0, -1);

        // Watchdog: emulator never activates
        emu_clear(); emu_dead = 1;
        set_cfg(4, 4, 1, 1, 1);
        push(K_START, 1); push(K_HSTOP, 0); push(K_DONE, 0);
        pulse_go();
        k = 0;
        while (!o_hstop && k < 64) begin
            @(posedge clk); #1; k++;
        end
        chk("wdog_cycles", k, 16);
        chk("wdog_err", o_err, 2);
        wait_done("wdog");
        post("wdog", 0, 2, -1);

        // Active FIFO mismatch during RUN0
        emu_clear(); emu_glitch = 1; beat_pct = 100;
        set_cfg(4, 4, 2, 1, 1);
        push(K_START, 1); push(K_HSTOP, 0); push(K_DONE, 0);
        pulse_go();
        wait_done("mism");
        post("mism", 0, 2, -1);

        // STOP in IDLE ignored, GO while busy ignored
        emu_clear(); beat_pct = 60;
        pulse_stop();
        set_cfg(6, 4, 2, 2, 2);
        exp_sched(2);
        pulse_go();
        repeat (10) @(negedge clk);
        pulse_go();
        wait_done("ignore");
        post("ignore", 2, 0, 2 * (6 * 2 + 4 * 2));

        // Randomised schedules
        for (int t = 0; t < 6; t++) begin
            emu_clear();
            beat_pct = $urandom_range(30, 100);
            c0 = $urandom_range(4, 7); c1 = $urandom_range(4, 7);
            r0 = $urandom_range(1, 3); r1 = $urandom_range(1, 3);
            cy = $urandom_range(0, 3);
            n = (cy != 0) ? cy : $urandom_range(1, 2);
            set_cfg(c0, c1, r0, r1, cy);
            exp_sched(n);
            pulse_go();
            if (cy == 0) begin
                wait_emu("rnd_stop", 1, -1, n - 1);
                pulse_stop();
            end
            wait_done("rnd");
            post("rnd", n, 0, n * (c0 * r0 + c1 * r1));
        end

        // Reset mid-run
        emu_clear(); beat_pct = 100;
        set_cfg(5, 5, 2, 2, 0);
        exp_sched(1);
        pulse_go();
        repeat (12) @(negedge clk);
        resetn = 0;
        @(negedge clk);
        chk("mid_rst_strobes", {o_start_we, o_hstop, o_done}, 0);
        chk("mid_rst_state", o_state, 0);
        chk("mid_rst_start", o_start, 0);
        chk("mid_rst_cycles", o_cyc_done, 0);
        exp_q.delete();
        @(negedge clk);
        resetn = 1;
        repeat (3) @(negedge clk);
        chk("mid_rst_idle", o_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
